// File: rtl/bit_serial_adder.sv
// Bit-serial adder controlling two upstream shift registers (load, then shift right).
// One operand pair is added LSB-first over WIDTH cycles; sum/cout are held until the next operation.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle when sum/cout are valid,
    // and they stay valid until the LOAD-exit edge of the next operation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s_bit;
    logic             carry_nxt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        s_bit     = a_bit ^ b_bit ^ carry_q;
        carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                carry_d = 1'b0;
                sum_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                // Counter holds at WIDTH-1 on the last edge so it never wraps.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = carry_nxt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        load_d = (state_d == LOAD);
        busy_d = (state_d == LOAD) || (state_d == ADD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load      = load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder: WIDTH=8 and WIDTH=16 instances fed by modelled upstream shift registers.
// Expected {cout,sum} and done cycle are queued at launch and checked when done pulses.
module tb_bit_serial_adder;

    localparam int W8  = 8;
    localparam int W16 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        rst8, start8, load8, busy8, done8, cout8;
    logic [7:0]  sum8, op_a8, op_b8, sa8, sb8;
    logic [1:0]  st8;
    logic        rst16, start16, load16, busy16, done16, cout16;
    logic [15:0] sum16, op_a16, op_b16, sa16, sb16;
    logic [1:0]  st16;

    logic [8:0]  exp_q8[$];
    int          cyc_q8[$];
    logic [16:0] exp_q16[$];
    int          cyc_q16[$];

    bit_serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a_bit(sa8[0]), .b_bit(sb8[0]),
        .load(load8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(st8)
    );

    bit_serial_adder #(.WIDTH(W16)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .a_bit(sa16[0]), .b_bit(sb16[0]),
        .load(load16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .state_dbg(st16)
    );

    // Upstream shift registers: parallel load, otherwise shift right with random fill.
    always @(posedge clk) begin
        if (load8) begin
            sa8 <= op_a8;
            sb8 <= op_b8;
        end else begin
            sa8 <= {1'($urandom), sa8[7:1]};
            sb8 <= {1'($urandom), sb8[7:1]};
        end
        if (load16) begin
            sa16 <= op_a16;
            sb16 <= op_b16;
        end else begin
            sa16 <= {1'($urandom), sa16[15:1]};
            sb16 <= {1'($urandom), sb16[15:1]};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp_q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done8_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                check("sum8", {cout8, sum8}, exp_q8.pop_front());
                check("lat8", cyc, cyc_q8.pop_front());
            end
        end
        if (done16 === 1'b1) begin
            if (exp_q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done16_unexpected: got done at cycle %0d expected none", cyc);
            end else begin
                check("sum16", {cout16, sum16}, exp_q16.pop_front());
                check("lat16", cyc, cyc_q16.pop_front());
            end
        end
    end

    // repulse >= 0 pulses start again during that ADD cycle index.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input int repulse);
        int n;
        int loads;
        @(negedge clk);
        op_a8  = a;
        op_b8  = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        exp_q8.push_back({1'b0, a} + {1'b0, b});
        cyc_q8.push_back(cyc + W8 + 1);
        loads = (load8 === 1'b1) ? 1 : 0;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (load8 === 1'b1) loads++;
            start8 = (n == repulse + 1) ? 1'b1 : 1'b0;
        end
        start8 = 1'b0;
        if (done8 !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout8: got no done after %0d cycles expected done", n);
        end
        check("load_cycles8", loads, 1);
        check("busy_at_done8", busy8, 0);
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        op_a16  = a;
        op_b16  = b;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        exp_q16.push_back({1'b0, a} + {1'b0, b});
        cyc_q16.push_back(cyc + W16 + 1);
        n = 0;
        while (done16 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done16 !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout16: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic reset_mid8();
        int nbusy;
        @(negedge clk);
        op_a8  = 8'hC3;
        op_b8  = 8'h5A;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_before_reset8", busy8, 1);
        #1 rst8 = 1'b1;
        #1;
        check("rst_load8", load8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        nbusy = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy8 !== 1'b0) nbusy++;
        end
        check("idle_after_reset8", nbusy, 0);
    endtask

    task automatic hold8();
        int c1;
        @(negedge clk);
        op_a8  = 8'h5C;
        op_b8  = 8'hA7;
        start8 = 1'b1;
        @(negedge clk);
        c1 = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_q8.push_back(9'h103);
            cyc_q8.push_back(c1 + k * (W8 + 3) + W8 + 1);
        end
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 30) start8 = 1'b0;
            check("hold_busy8", busy8, (((c - 1) % (W8 + 3)) <= W8) ? 1 : 0);
        end
    endtask

    initial begin
        rst8    = 1'b1;
        rst16   = 1'b1;
        start8  = 1'b0;
        start16 = 1'b0;
        op_a8   = '0;
        op_b8   = '0;
        op_a16  = '0;
        op_b16  = '0;
        repeat (3) @(negedge clk);
        check("reset_load8", load8, 0);
        check("reset_busy8", busy8, 0);
        check("reset_done8", done8, 0);
        check("reset_sum8", {cout8, sum8}, 0);
        check("reset_busy16", busy16, 0);
        check("reset_sum16", {cout16, sum16}, 0);
        rst8  = 1'b0;
        rst16 = 1'b0;
        repeat (2) @(negedge clk);

        issue8(8'h35, 8'h4A, -1);
        issue8(8'hFF, 8'h01, -1);
        issue8(8'hFF, 8'hFF, -1);
        reset_mid8();
        issue8(8'h10, 8'h20, -1);
        issue8(8'h66, 8'h9B, 3);
        repeat (3) @(negedge clk);
        hold8();
        repeat (4) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue8(8'($urandom), 8'($urandom), -1);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue16(16'($urandom), 16'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join

        repeat (4) @(negedge clk);
        check("pending8", exp_q8.size(), 0);
        check("pending16", exp_q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        bad++;
        $display("FAIL global_timeout: got still running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
